// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests, buffers returned words in order.
// Define IFU_PERF_CNT_EN to add fetch_bubble_cnt_out, a saturating count of cycles the decoder waited on fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        imem_req_valid_out,
    input  logic        imem_req_ready_in,
    output logic [31:0] imem_req_addr_out,
    input  logic        imem_rsp_valid_in,
    input  logic [31:0] imem_rsp_data_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_bubble_cnt_out
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_W  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];

    logic            req_valid, accept, push, pop, rsp_dec, credit_ok;
    logic [CW-1:0]   inflight_after;

    assign instr_valid_out    = (count_q != '0);
    assign instr_out          = instr_valid_out ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign instr_pc_out       = instr_valid_out ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign imem_req_valid_out = req_valid;
    assign imem_req_addr_out  = fetch_pc_q;

    // Responses can only belong to accepted requests; guarding keeps counters from underflowing.
    assign rsp_dec        = imem_rsp_valid_in && (inflight_q != '0);
    assign inflight_after = inflight_q - CW'(rsp_dec);
    assign credit_ok      = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        req_valid  = 1'b0;
        push       = 1'b0;
        pop        = instr_valid_out && instr_ready_in && !redirect_valid_in;

        if (state_q == FETCH) begin
            req_valid = !redirect_valid_in && credit_ok;
        end
        accept = req_valid && imem_req_ready_in;

        if (redirect_valid_in) begin
            fetch_pc_d = {redirect_pc_in[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc_in[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = inflight_after;
            discard_d  = inflight_after;
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = (inflight_after != '0) ? FLUSH : FETCH;
                default: state_d = FLUSH;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (accept) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    if (rsp_dec) begin
                        rsp_pc_d = rsp_pc_q + 32'd4;
                        push     = (count_q != FULL_W);
                    end
                    inflight_d = inflight_q + CW'(accept) - CW'(rsp_dec);
                end
                default: begin
                    if (rsp_dec) begin
                        inflight_d = inflight_after;
                        discard_d  = discard_q - CW'(discard_q != '0);
                    end
                    state_d = (discard_d == '0) ? FETCH : FLUSH;
                end
            endcase
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the count is zero.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rsp_data_in;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((state_q == FETCH || state_q == FLUSH) && !instr_valid_out && instr_ready_in
            && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bubble_cnt_q <= 32'h0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_bubble_cnt_out = bubble_cnt_q;
`endif

endmodule
